// File: rtl/i2c_eeprom_slave_pkg.sv
// Shared I2C definitions: field widths and the slave protocol states.
package i2c_eeprom_slave_pkg;
   localparam int unsigned I2C_ADDR_W = 7;
   localparam int unsigned I2C_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      WAIT_STOP
   } i2c_state_e;
endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes SCL/SDA into the clk domain and flags SCL edges plus START/STOP.
module i2c_bus_monitor #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);
   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl;
   logic                   scl_prev;
   logic                   sda_prev;

   always_ff @(posedge clk) begin
      if (!rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_sync[0] <= scl_in;
         sda_sync[0] <= sda_in;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            scl_sync[i] <= scl_sync[i-1];
            sda_sync[i] <= sda_sync[i-1];
         end
         scl_prev <= scl;
         sda_prev <= sda;
      end
   end

   assign scl      = scl_sync[SYNC_STAGES-1];
   assign sda      = sda_sync[SYNC_STAGES-1];
   assign scl_rise = scl & ~scl_prev;
   assign scl_fall = ~scl & scl_prev;
   // SCL must be high in both samples so a simultaneous SCL/SDA move is not a condition
   assign start    = scl & scl_prev & sda_prev & ~sda;
   assign stop     = scl & scl_prev & ~sda_prev & sda;
endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C slave exposing a byte-wide memory with an auto-incrementing 7-bit word pointer.
module i2c_eeprom_slave
   import i2c_eeprom_slave_pkg::*;
#(
   parameter int unsigned MEM_DEPTH   = 128,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  scl_in,
   input  logic                  sda_in,
   output logic                  sda_oe,
   output logic                  busy,
   output logic                  wr_strobe,
   output logic                  rd_strobe,
   output logic [I2C_ADDR_W-1:0] last_addr,
   output logic [I2C_DATA_W-1:0] last_data
);
   localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   logic sda, scl_rise, scl_fall, start, stop;

   i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) mon (
      .clk      (clk),
      .rst      (rst),
      .scl_in   (scl_in),
      .sda_in   (sda_in),
      .sda      (sda),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );

   i2c_state_e            state, state_n;
   logic [3:0]            bit_cnt, bit_cnt_n;
   logic [I2C_DATA_W-1:0] shreg, shreg_n;
   logic [I2C_ADDR_W-1:0] ptr, ptr_n;
   logic                  rw, rw_n;
   logic                  sda_oe_n, busy_n, wr_strobe_n, rd_strobe_n;
   logic [I2C_ADDR_W-1:0] last_addr_n;
   logic [I2C_DATA_W-1:0] last_data_n;
   logic                  mem_we, load;
   logic [IDX_W-1:0]      idx;
   logic [I2C_DATA_W-1:0] rd_byte;
   logic [I2C_DATA_W-1:0] mem [MEM_DEPTH];

   assign idx     = ptr[IDX_W-1:0];
   assign rd_byte = mem[idx];

   always_comb begin
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      shreg_n     = shreg;
      ptr_n       = ptr;
      rw_n        = rw;
      sda_oe_n    = sda_oe;
      busy_n      = busy;
      wr_strobe_n = 1'b0;
      rd_strobe_n = 1'b0;
      last_addr_n = last_addr;
      last_data_n = last_data;
      mem_we      = 1'b0;
      load        = 1'b0;
      if (start) begin
         state_n   = ADDR;
         bit_cnt_n = '0;
         sda_oe_n  = 1'b0;
         busy_n    = 1'b1;
      end else if (stop) begin
         state_n   = IDLE;
         bit_cnt_n = '0;
         sda_oe_n  = 1'b0;
         busy_n    = 1'b0;
      end else begin
         case (state)
            ADDR, WR_DATA: begin
               if (scl_rise && bit_cnt < 4'd8) begin
                  shreg_n   = {shreg[I2C_DATA_W-2:0], sda};
                  bit_cnt_n = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  sda_oe_n  = 1'b1;
                  bit_cnt_n = '0;
                  if (state == ADDR) begin
                     ptr_n   = shreg[I2C_DATA_W-1:1];
                     rw_n    = shreg[0];
                     state_n = ADDR_ACK;
                  end else begin
                     mem_we      = 1'b1;
                     wr_strobe_n = 1'b1;
                     last_addr_n = ptr;
                     last_data_n = shreg;
                     state_n     = WR_ACK;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (rw) begin
                     load = 1'b1;
                  end else begin
                     sda_oe_n = 1'b0;
                     state_n  = WR_DATA;
                  end
               end
            end
            WR_ACK: begin
               if (scl_fall) begin
                  sda_oe_n = 1'b0;
                  ptr_n    = ptr + 7'd1;
                  state_n  = WR_DATA;
               end
            end
            RD_DATA: begin
               if (scl_fall) begin
                  if (bit_cnt == 4'd7) begin
                     sda_oe_n  = 1'b0;
                     bit_cnt_n = '0;
                     state_n   = RD_ACK;
                  end else begin
                     shreg_n   = {shreg[I2C_DATA_W-2:0], 1'b0};
                     sda_oe_n  = ~shreg[I2C_DATA_W-2];
                     bit_cnt_n = bit_cnt + 4'd1;
                  end
               end
            end
            RD_ACK: begin
               // bit_cnt doubles as "master ACKed" between the ACK rise and the following fall
               if (scl_rise) begin
                  if (sda) begin
                     state_n = WAIT_STOP;
                  end else begin
                     ptr_n     = ptr + 7'd1;
                     bit_cnt_n = 4'd1;
                  end
               end else if (scl_fall && bit_cnt == 4'd1) begin
                  load = 1'b1;
               end
            end
            IDLE, WAIT_STOP: ;
            default: state_n = IDLE;
         endcase
         if (load) begin
            shreg_n     = rd_byte;
            sda_oe_n    = ~rd_byte[I2C_DATA_W-1];
            rd_strobe_n = 1'b1;
            last_addr_n = ptr;
            last_data_n = rd_byte;
            bit_cnt_n   = '0;
            state_n     = RD_DATA;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         ptr       <= '0;
         rw        <= 1'b0;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         wr_strobe <= 1'b0;
         rd_strobe <= 1'b0;
         last_addr <= '0;
         last_data <= '0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         shreg     <= shreg_n;
         ptr       <= ptr_n;
         rw        <= rw_n;
         sda_oe    <= sda_oe_n;
         busy      <= busy_n;
         wr_strobe <= wr_strobe_n;
         rd_strobe <= rd_strobe_n;
         last_addr <= last_addr_n;
         last_data <= last_data_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && mem_we) mem[idx] <= shreg;
   end
endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: bit-banged I2C master, array memory model and strobe scoreboard.
module tb_i2c_eeprom_slave;
   import i2c_eeprom_slave_pkg::*;

   localparam int Q = 8;

   logic clk = 1'b0, rst = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
   logic scl_in, sda_in, sda_oe, busy, wr_strobe, rd_strobe;
   logic [6:0] last_addr;
   logic [7:0] last_data;

   assign scl_in = scl_m;
   assign sda_in = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_eeprom_slave #(.MEM_DEPTH(128), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .sda_oe    (sda_oe),
      .busy      (busy),
      .wr_strobe (wr_strobe),
      .rd_strobe (rd_strobe),
      .last_addr (last_addr),
      .last_data (last_data)
   );

   typedef struct {
      bit         is_rd;
      logic [6:0] addr;
      logic [7:0] data;
      bit         known;
   } exp_t;

   exp_t       sb[$];
   int         vectors = 0, miscompares = 0;
   logic [7:0] ref_mem [128];
   bit         ref_valid [128];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // strobe monitor: each strobe consumes one expected transfer
   always @(negedge clk) begin : strobe_mon
      exp_t e;
      if (rst && (wr_strobe || rd_strobe)) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_strobe: wr=%0b rd=%0b addr=0x%0h, expected no strobe",
                     wr_strobe, rd_strobe, last_addr);
         end else begin
            e = sb.pop_front();
            check("strobe_rd", 32'(rd_strobe), 32'(e.is_rd));
            check("strobe_wr", 32'(wr_strobe), 32'(!e.is_rd));
            check("last_addr", 32'(last_addr), 32'(e.addr));
            if (e.known) check("last_data", 32'(last_data), 32'(e.data));
         end
      end
   end

   // SDA may only move while SCL is low
   logic [3:0] scl_hist = '0;
   logic       oe_prev = 1'b0, rst_prev = 1'b0;
   always @(negedge clk) begin
      if (rst && rst_prev && sda_oe !== oe_prev) begin
         vectors++;
         if (scl_in && scl_hist == 4'hF) begin
            miscompares++;
            $display("FAIL sda_oe_scl_high: sda_oe moved to %0b while SCL high, required stable", sda_oe);
         end
      end
      oe_prev  = sda_oe;
      rst_prev = rst;
      scl_hist = {scl_hist[2:0], scl_in};
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      sda_m = b; tick(Q);
      scl_m = 1'b1; tick(2 * Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic recv_bit(output logic b);
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      b = sda_in; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b1; tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic nack);
      logic b;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         recv_bit(b);
         d = {d[6:0], b};
      end
      send_bit(nack);
   endtask

   task automatic end_checks();
      tick(4);
      check("busy_after_stop", 32'(busy), 32'd0);
      check("idle_after_stop", 32'(dut.state), 32'(IDLE));
   endtask

   task automatic do_write(input logic [6:0] a, input logic [7:0] bytes [$]);
      logic       ack;
      logic [6:0] p;
      p = a;
      i2c_start();
      check("busy_after_start", 32'(busy), 32'd1);
      write_byte({a, 1'b0}, ack);
      check("addr_ack_w", 32'(ack), 32'd0);
      foreach (bytes[i]) begin
         sb.push_back('{1'b0, p, bytes[i], 1'b1});
         ref_mem[p]   = bytes[i];
         ref_valid[p] = 1'b1;
         write_byte(bytes[i], ack);
         check("data_ack", 32'(ack), 32'd0);
         p = p + 7'd1;
      end
      i2c_stop();
      end_checks();
   endtask

   task automatic do_read(input logic [6:0] a, input int n);
      logic       ack;
      logic [7:0] d;
      logic [6:0] p, q;
      p = a;
      i2c_start();
      sb.push_back('{1'b1, p, ref_mem[p], ref_valid[p]});
      write_byte({a, 1'b1}, ack);
      check("addr_ack_r", 32'(ack), 32'd0);
      for (int i = 0; i < n; i++) begin
         q = p + 7'd1;
         if (i < n - 1) sb.push_back('{1'b1, q, ref_mem[q], ref_valid[q]});
         read_byte(d, i == n - 1);
         if (ref_valid[p]) check("read_data", 32'(d), 32'(ref_mem[p]));
         p = q;
      end
      tick(4);
      check("wait_stop_after_nack", 32'(dut.state), 32'(WAIT_STOP));
      i2c_stop();
      end_checks();
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL timeout: simulation still running, required completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [7:0] bq[$];
      logic       ack, b;
      logic [6:0] a, last_wr;
      int         n;

      tick(4);
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
      check("rst_rd_strobe", 32'(rd_strobe), 32'd0);
      check("rst_last_addr", 32'(last_addr), 32'd0);
      check("rst_last_data", 32'(last_data), 32'd0);
      check("rst_state", 32'(dut.state), 32'(IDLE));
      rst = 1'b1;
      tick(4);

      bq = '{8'hAA};
      do_write(7'h50, bq);
      check("w50_last_addr", 32'(last_addr), 32'h50);
      check("w50_last_data", 32'(last_data), 32'hAA);
      do_read(7'h50, 1);

      bq = '{8'h11, 8'h22};
      do_write(7'h7F, bq);
      check("wrap_last_addr", 32'(last_addr), 32'h00);
      do_read(7'h7F, 2);

      // write aborted by repeated START during the 4th data bit
      bq = '{8'h77};
      do_write(7'h30, bq);
      i2c_start();
      write_byte({7'h30, 1'b0}, ack);
      check("abort_addr_ack", 32'(ack), 32'd0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      i2c_start();
      write_byte({7'h31, 1'b0}, ack);
      check("restart_addr_ack", 32'(ack), 32'd0);
      sb.push_back('{1'b0, 7'h31, 8'h5C, 1'b1});
      ref_mem[7'h31]   = 8'h5C;
      ref_valid[7'h31] = 1'b1;
      write_byte(8'h5C, ack);
      check("restart_data_ack", 32'(ack), 32'd0);
      i2c_stop();
      end_checks();
      check("restart_last_addr", 32'(last_addr), 32'h31);
      do_read(7'h30, 2);

      // reset while the slave holds SDA low for a read bit
      i2c_start();
      sb.push_back('{1'b1, 7'h50, 8'hAA, 1'b1});
      write_byte({7'h50, 1'b1}, ack);
      check("rst_rd_addr_ack", 32'(ack), 32'd0);
      recv_bit(b);
      check("rst_rd_bit7", 32'(b), 32'd1);
      check("rst_rd_drive_low", 32'(sda_oe), 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;
      check("midrst_sda_oe", 32'(sda_oe), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_state", 32'(dut.state), 32'(IDLE));
      rst = 1'b1;
      tick(2);
      i2c_stop();
      end_checks();

      last_wr = 7'h50;
      for (int t = 0; t < 14; t++) begin
         a = 7'($urandom_range(0, 127));
         n = $urandom_range(1, 4);
         if ($urandom_range(0, 1) == 0) begin
            bq.delete();
            for (int k = 0; k < n; k++) bq.push_back(8'($urandom));
            do_write(a, bq);
            last_wr = a;
         end else begin
            do_read(($urandom_range(0, 2) == 0) ? a : last_wr, n);
         end
      end

      tick(20);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/i2c_eeprom_slave.md
I2C_EEPROM_SLAVE -- requirements
Module: i2c_eeprom_slave

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 128, number of 8-bit storage locations addressed by a 7-bit word address.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops on scl_in and sda_in.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port scl_in  input  1  I2C clock sampled from the bus, asynchronous to clk.
REQ-006 SHALL have port sda_in  input  1  I2C data sampled from the bus, asynchronous to clk.
REQ-007 SHALL have port sda_oe  output  1  open-drain pull-down enable; 1 drives SDA low, 0 releases it.
REQ-008 SHALL have port busy  output  1  high from a detected START until the next STOP.
REQ-009 SHALL have port wr_strobe  output  1  one-cycle pulse when a received data byte is committed to memory.
REQ-010 SHALL have port rd_strobe  output  1  one-cycle pulse when a memory byte is loaded for transmission.
REQ-011 SHALL have port last_addr  output  7  word address of the most recent wr_strobe or rd_strobe.
REQ-012 SHALL have port last_data  output  8  data byte of the most recent wr_strobe or rd_strobe.

Function
REQ-013 SHALL pass scl_in/sda_in through SYNC_STAGES flops, then one more register for edge detection; SCL rise/fall derived from the last two SCL samples.
REQ-014 SHALL detect START as synchronized SDA falling while SCL high, and STOP as SDA rising while SCL high.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-016 SHALL enter ADDR from any state on START, including repeated START; bit counter cleared, sda_oe released.
REQ-017 SHALL return to IDLE from any state on STOP, with sda_oe released in the same cycle.
REQ-018 SHALL sample SDA on each SCL rising edge in ADDR/WR_DATA, MSB first, eight bits per byte.
REQ-019 SHALL treat the first byte as {word_addr[6:0], rw}; rw=0 write, rw=1 read; every address is accepted.
REQ-020 SHALL assert sda_oe on the SCL falling edge after the 8th bit of each received byte (ACK), and release it on the next SCL falling edge.
REQ-021 SHALL, for rw=0, after ADDR_ACK go to WR_DATA; after 8 bits, store the byte at the pointer, pulse wr_strobe, ACK (WR_ACK), then increment the pointer.
REQ-022 SHALL, for rw=1, pulse rd_strobe and load mem[pointer] at the SCL falling edge that ends ADDR_ACK/RD_ACK, driving bit7 on that edge.
REQ-023 SHALL in RD_DATA update sda_oe = ~bit only on SCL falling edges, so SDA is never changed while SCL is high.
REQ-024 SHALL in RD_ACK release SDA, sample master ACK on SCL rise: ACK (0) -> increment pointer, next byte; NACK (1) -> WAIT_STOP with SDA released.
REQ-025 SHALL wrap the 7-bit pointer from 127 to 0; with MEM_DEPTH < 128, address bits above log2(MEM_DEPTH) are ignored.
REQ-026 SHALL, for a byte interrupted by START or STOP, discard it with no memory write and no strobe.
REQ-027 SHALL have memory contents not cleared by reset; read before write returns undefined data.

Reset
REQ-028 SHALL, while rst=0 at a clk edge, force IDLE, sda_oe=0, busy=0, wr_strobe=0, rd_strobe=0, last_addr=0, last_data=0, pointer=0, bit counter=0, synchronizers=1 (idle bus).
REQ-029 SHALL, on reset mid-transaction, release SDA immediately and ignore the bus until the next START.

Structure
REQ-030 SHALL place the state enumeration, I2C_ADDR_W=7 and I2C_DATA_W=8 in a shared I2C package used with the bus master.
REQ-031 SHALL implement the synchronizer plus START/STOP/edge detector as sub-module i2c_bus_monitor; storage is an inferred array in this module.

Verification
REQ-032 SHALL cover: write 0xAA to address 0x50 then STOP -> wr_strobe once, last_addr=0x50, last_data=0xAA, two ACK low pulses seen.
REQ-033 SHALL cover: after REQ-032, read address 0x50 with NACK -> SDA bits 10101010, rd_strobe once, WAIT_STOP then IDLE on STOP.
REQ-034 SHALL cover: sequential write 0x11,0x22 starting at 0x7F, then reads -> mem[0x7F]=0x11, mem[0x00]=0x22 (wrap).
REQ-035 SHALL cover: START during the 4th data bit of a write -> no wr_strobe, new address phase accepted.
REQ-036 SHALL cover: rst=0 while driving a read bit low -> sda_oe=0 next clk, busy=0, state IDLE.
REQ-037 SHALL cover: a bench checker that flags any sda_oe change while synchronized SCL is high, outside START/STOP handling.
